// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: mode codes, register indices,
// R1 / R0 / status bit positions, CPU-port state encoding and the mode decode.
package vdp_pkg;

  localparam int unsigned VDP_ADDR_W = 14;
  localparam int unsigned VDP_NREGS  = 8;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_G1   = 2'd1,
    MODE_G2   = 2'd2,
    MODE_MC   = 2'd3
  } vdp_mode_e;

  // Register indices
  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  // R1 bit positions
  localparam logic [2:0] R1_BLANK = 3'd6;
  localparam logic [2:0] R1_IE    = 3'd5;
  localparam logic [2:0] R1_M1    = 3'd4;
  localparam logic [2:0] R1_M2    = 3'd3;
  localparam logic [2:0] R1_SIZE  = 3'd1;
  localparam logic [2:0] R1_MAG   = 3'd0;

  // R0 bit position of M3
  localparam logic [2:0] R0_M3 = 3'd1;

  // Status bit positions
  localparam logic [2:0] ST_F  = 3'd7;
  localparam logic [2:0] ST_5S = 3'd6;
  localparam logic [2:0] ST_C  = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    PREFETCH = 1'b1
  } vdp_state_e;

  // Mode select with priority M1 > M3 > M2
  function automatic vdp_mode_e decode_mode(input logic m1, input logic m2, input logic m3);
    if (m1)      return MODE_TEXT;
    else if (m3) return MODE_G2;
    else if (m2) return MODE_MC;
    else         return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_status_latch.sv
// VDP status register (F, 5S, C, fifth sprite number) and CPU interrupt.
// Ports: cpu_clk/n_reset; frame_int, sprite_collision, too_many_sprites,
// sprite5 set events; clr = accepted status read; ie = R1 interrupt enable;
// status = {F, 5S, C, fifth}; n_int = active-low interrupt.
module vdp_status_latch
  import vdp_pkg::*;
(
  input  logic       cpu_clk,
  input  logic       n_reset,
  input  logic       frame_int,
  input  logic       sprite_collision,
  input  logic       too_many_sprites,
  input  logic [4:0] sprite5,
  input  logic       clr,
  input  logic       ie,
  output logic [7:0] status,
  output logic       n_int
);

  logic       f;
  logic       s5;
  logic       c;
  logic [4:0] fifth;

  // A set event in the same cycle as a clearing read wins over the clear
  always_ff @(posedge cpu_clk) begin
    if (!n_reset) begin
      f     <= 1'b0;
      s5    <= 1'b0;
      c     <= 1'b0;
      fifth <= 5'd0;
    end else begin
      f  <= frame_int | (f & ~clr);
      c  <= sprite_collision | (c & ~clr);
      s5 <= too_many_sprites | (s5 & ~clr);
      // fifth follows sprite5 until 5S latches, then freezes
      if (!s5) fifth <= sprite5;
    end
  end

  always_comb begin
    status        = 8'd0;
    status[ST_F]  = f;
    status[ST_5S] = s5;
    status[ST_C]  = c;
    status[4:0]   = fifth;
  end

  assign n_int = ~(f & ie);

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side port of the VDP: decodes data (port 0) / control (port 1) I/O,
// drives VRAM port A with an auto-incrementing address and read-ahead buffer,
// holds R0-R7 and breaks them out for the video generator, and owns status/int.
// Ports: cpu_clk/n_reset; io_port/io_wr/io_rd/cpu_din/cpu_dout CPU bus;
// vram_addr/vram_dout/vram_we/vram_re/vram_din VRAM port A; frame_int and
// sprite events in; mode, table addresses, colours, R1 flags, n_int out.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W = VDP_ADDR_W,
  parameter int unsigned NREGS  = VDP_NREGS
)(
  input  logic              cpu_clk,
  input  logic              n_reset,
  input  logic              io_port,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_dout,
  output logic              vram_we,
  output logic              vram_re,
  input  logic [7:0]        vram_din,
  input  logic              frame_int,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              video_on,
  output logic              vert_retrace_int,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic              n_int
);

  vdp_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        read_buf;
  logic [7:0]        first;
  logic              latch_flag;
  logic              err_overrun;
  logic [7:0]        regs [NREGS];
  logic [7:0]        status;

  logic idle, wr_ok, rd_ok, strobe_drop;
  logic data_wr, data_rd, ctrl_wr, stat_rd;

  // Strobe qualification: write beats read, anything during a prefetch is lost
  assign idle        = (state == IDLE);
  assign wr_ok       = io_wr & idle;
  assign rd_ok       = io_rd & ~io_wr & idle;
  assign strobe_drop = (io_wr | io_rd) & ~idle;
  assign data_wr     = wr_ok & ~io_port;
  assign ctrl_wr     = wr_ok &  io_port;
  assign data_rd     = rd_ok & ~io_port;
  assign stat_rd     = rd_ok &  io_port;

  // VRAM write happens in the strobe cycle itself
  assign vram_addr = addr;
  assign vram_dout = cpu_din;
  assign vram_we   = data_wr;

  assign cpu_dout = stat_rd ? status : read_buf;

  // Prefetch runs two cycles: vram_re high (issue), then capture of vram_din
  always_ff @(posedge cpu_clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      addr        <= '0;
      read_buf    <= 8'd0;
      first       <= 8'd0;
      latch_flag  <= 1'b0;
      vram_re     <= 1'b0;
      err_overrun <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= 8'd0;
    end else begin
      err_overrun <= err_overrun | strobe_drop;
      case (state)
        IDLE: begin
          if (data_wr) begin
            read_buf   <= cpu_din;
            addr       <= addr + ADDR_W'(1);
            latch_flag <= 1'b0;
          end else if (data_rd) begin
            state      <= PREFETCH;
            vram_re    <= 1'b1;
            latch_flag <= 1'b0;
          end else if (stat_rd) begin
            latch_flag <= 1'b0;
          end else if (ctrl_wr) begin
            if (!latch_flag) begin
              first      <= cpu_din;
              latch_flag <= 1'b1;
            end else begin
              latch_flag <= 1'b0;
              if (cpu_din[7]) begin
                regs[cpu_din[2:0]] <= first;
              end else begin
                addr <= ADDR_W'({cpu_din[5:0], first});
                // 00 = read setup: prefetch from the new address
                if (!cpu_din[6]) begin
                  state   <= PREFETCH;
                  vram_re <= 1'b1;
                end
              end
            end
          end
        end
        PREFETCH: begin
          if (vram_re) begin
            vram_re <= 1'b0;
            addr    <= addr + ADDR_W'(1);
          end else begin
            read_buf <= vram_din;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register breakouts for the video generator
  assign mode = decode_mode(regs[REG_R1][R1_M1], regs[REG_R1][R1_M2], regs[REG_R0][R0_M3]);
  assign name_table_addr           = {regs[REG_R2][3:0], 10'b0};
  assign color_table_addr          = {regs[REG_R3], 6'b0};
  assign font_addr                 = {regs[REG_R4][2:0], 11'b0};
  assign sprite_attr_addr          = {regs[REG_R5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs[REG_R6][2:0], 11'b0};
  assign text_color                = regs[REG_R7][7:4];
  assign back_color                = regs[REG_R7][3:0];
  assign video_on                  = regs[REG_R1][R1_BLANK];
  assign vert_retrace_int          = regs[REG_R1][R1_IE];
  assign sprite_large              = regs[REG_R1][R1_SIZE];
  assign sprite_enlarged           = regs[REG_R1][R1_MAG];

  vdp_status_latch u_status (
    .cpu_clk          (cpu_clk),
    .n_reset          (n_reset),
    .frame_int        (frame_int),
    .sprite_collision (sprite_collision),
    .too_many_sprites (too_many_sprites),
    .sprite5          (sprite5),
    .clr              (stat_rd),
    .ie               (regs[REG_R1][R1_IE]),
    .status           (status),
    .n_int            (n_int)
  );

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios plus a random access sequence,
// checked against an access-level model of the VDP CPU port.
module tb_vdp_cpu_port;

  logic        cpu_clk = 1'b0;
  logic        n_reset;
  logic        io_port, io_wr, io_rd;
  logic [7:0]  cpu_din, cpu_dout;
  logic [13:0] vram_addr;
  logic [7:0]  vram_dout, vram_din;
  logic        vram_we, vram_re;
  logic        frame_int, sprite_collision, too_many_sprites;
  logic [4:0]  sprite5;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic [3:0]  text_color, back_color;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged, n_int;

  int checks = 0;
  int fails  = 0;

  always #5 cpu_clk = ~cpu_clk;

  vdp_cpu_port #(.ADDR_W(14), .NREGS(8)) dut (
    .cpu_clk(cpu_clk), .n_reset(n_reset), .io_port(io_port), .io_wr(io_wr),
    .io_rd(io_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr),
    .vram_dout(vram_dout), .vram_we(vram_we), .vram_re(vram_re), .vram_din(vram_din),
    .frame_int(frame_int), .sprite_collision(sprite_collision),
    .too_many_sprites(too_many_sprites), .sprite5(sprite5), .mode(mode),
    .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
    .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr), .text_color(text_color),
    .back_color(back_color), .video_on(video_on), .vert_retrace_int(vert_retrace_int),
    .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged), .n_int(n_int)
  );

  // VRAM attached to port A: write in the strobe cycle, read data one cycle after vram_re
  logic [7:0] vmem [16384];
  always @(posedge cpu_clk) begin
    if (vram_we) vmem[vram_addr] = vram_dout;
    if (vram_re) vram_din <= vmem[vram_addr];
  end

  // Log of VRAM accesses seen on the port
  logic [13:0] re_log [$];
  logic [21:0] we_log [$];
  always @(negedge cpu_clk) begin
    if (n_reset === 1'b1) begin
      if (vram_re === 1'b1) re_log.push_back(vram_addr);
      if (vram_we === 1'b1) we_log.push_back({vram_addr, vram_dout});
    end
  end

  // ---------------- reference model (one step per CPU access) ----------------
  logic [7:0] m_mem [16384];
  int         m_addr;
  logic [7:0] m_buf, m_first;
  bit         m_latch;
  int         m_regs [8];
  bit         m_F, m_5S, m_C;
  logic [4:0] m_fifth;

  task automatic m_reset();
    m_addr = 0; m_buf = 8'h00; m_first = 8'h00; m_latch = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_F = 0; m_5S = 0; m_C = 0; m_fifth = 5'd0;
  endtask

  task automatic m_prefetch();
    m_buf  = m_mem[m_addr];
    m_addr = (m_addr + 1) % 16384;
  endtask

  task automatic m_data_wr(input logic [7:0] d);
    m_mem[m_addr] = d;
    m_buf   = d;
    m_addr  = (m_addr + 1) % 16384;
    m_latch = 0;
  endtask

  task automatic m_data_rd(output logic [7:0] r);
    r = m_buf;
    m_prefetch();
    m_latch = 0;
  endtask

  task automatic m_ctrl_wr(input logic [7:0] d);
    int v;
    v = int'(d);
    if (!m_latch) begin
      m_first = d;
      m_latch = 1;
    end else begin
      m_latch = 0;
      if (v >= 128) m_regs[v % 8] = int'(m_first);
      else begin
        m_addr = (v % 64) * 256 + int'(m_first);
        if (v < 64) m_prefetch();
      end
    end
  endtask

  task automatic m_stat_rd(output logic [7:0] s);
    s = {m_F, m_5S, m_C, m_fifth};
    m_F = 0; m_5S = 0; m_C = 0;
    m_latch = 0;
  endtask

  function automatic logic [83:0] exp_outputs();
    int r0, r1, r2, r3, r4, r5, r6, r7;
    logic [1:0] md;
    r0 = m_regs[0]; r1 = m_regs[1]; r2 = m_regs[2]; r3 = m_regs[3];
    r4 = m_regs[4]; r5 = m_regs[5]; r6 = m_regs[6]; r7 = m_regs[7];
    if ((r1 / 16) % 2 == 1)     md = 2'd0;
    else if ((r0 / 2) % 2 == 1) md = 2'd2;
    else if ((r1 / 8) % 2 == 1) md = 2'd3;
    else                        md = 2'd1;
    return {md, 14'((r2 % 16) * 1024), 14'(r3 * 64), 14'((r4 % 8) * 2048),
            14'((r5 % 128) * 128), 14'((r6 % 8) * 2048), 4'(r7 / 16), 4'(r7 % 16),
            1'((r1 / 64) % 2), 1'((r1 / 32) % 2), 1'((r1 / 2) % 2), 1'(r1 % 2)};
  endfunction

  logic [83:0] obs_regs;
  assign obs_regs = {mode, name_table_addr, color_table_addr, font_addr, sprite_attr_addr,
                     sprite_pattern_table_addr, text_color, back_color, video_on,
                     vert_retrace_int, sprite_large, sprite_enlarged};

  // ---------------- stimulus helpers ----------------
  logic [7:0]  s_dout, s_vdout;
  logic [13:0] s_addr;
  logic        s_we;

  task automatic tick();
    @(posedge cpu_clk); #1;
  endtask

  // One-cycle strobe; strobe-cycle outputs captured at the falling edge
  task automatic io(input bit wr, input bit rd, input bit port, input logic [7:0] d);
    io_wr = wr; io_rd = rd; io_port = port; cpu_din = d;
    @(negedge cpu_clk);
    s_dout = cpu_dout; s_we = vram_we; s_addr = vram_addr; s_vdout = vram_dout;
    @(posedge cpu_clk); #1;
    io_wr = 1'b0; io_rd = 1'b0;
  endtask

  task automatic gap();
    repeat (2) tick();
  endtask

  task automatic ctrl(input logic [7:0] d);
    io(1, 0, 1, d); m_ctrl_wr(d); gap();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_reset = 1'b0; repeat (2) tick(); n_reset = 1'b1; tick();
    m_reset();
    checks++; if (cpu_dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", cpu_dout); end
    checks++; if (vram_addr !== 14'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", vram_addr); end
    checks++; if (vram_we !== 1'b0 || vram_re !== 1'b0) begin fails++; $display("FAIL reset_we_re: got %b%b want 00", vram_we, vram_re); end
    checks++; if (n_int !== 1'b1) begin fails++; $display("FAIL reset_nint: got %b want 1", n_int); end
    checks++; if (obs_regs !== exp_outputs()) begin fails++; $display("FAIL reset_regs: got %h want %h", obs_regs, exp_outputs()); end
    checks++; if (dut.err_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", dut.err_overrun); end
    // reset during the issue cycle of a prefetch abandons the capture
    io(1, 0, 1, 8'h00); gap();
    io(1, 0, 1, 8'h00);
    n_reset = 1'b0; tick(); n_reset = 1'b1; gap();
    m_reset();
    checks++; if (cpu_dout !== 8'h00) begin fails++; $display("FAIL reset_midpf_buf: got %h want 00", cpu_dout); end
    checks++; if (vram_re !== 1'b0 || vram_addr !== 14'h0000) begin fails++; $display("FAIL reset_midpf_port: got re=%b addr=%h want re=0 addr=0000", vram_re, vram_addr); end
  endtask

  task automatic test_write_setup();
    re_log.delete(); we_log.delete();
    ctrl(8'h00); ctrl(8'h40);
    io(1, 0, 0, 8'hAA); m_data_wr(8'hAA);
    checks++; if (s_we !== 1'b1 || s_addr !== 14'h0000 || s_vdout !== 8'hAA) begin fails++; $display("FAIL wr_first: got we=%b addr=%h d=%h want 1 0000 aa", s_we, s_addr, s_vdout); end
    gap();
    io(1, 0, 0, 8'hBB); m_data_wr(8'hBB);
    checks++; if (s_we !== 1'b1 || s_addr !== 14'h0001 || s_vdout !== 8'hBB) begin fails++; $display("FAIL wr_second: got we=%b addr=%h d=%h want 1 0001 bb", s_we, s_addr, s_vdout); end
    gap();
    checks++; if (vram_addr !== 14'h0002 || vram_addr !== 14'(m_addr)) begin fails++; $display("FAIL wr_end_addr: got %h want 0002", vram_addr); end
    checks++; if (we_log.size() != 2 || re_log.size() != 0) begin fails++; $display("FAIL wr_pulses: got we=%0d re=%0d want we=2 re=0", we_log.size(), re_log.size()); end
    checks++; if (cpu_dout !== 8'hBB) begin fails++; $display("FAIL wr_readbuf: got %h want bb", cpu_dout); end
  endtask

  task automatic test_read_prefetch();
    logic [7:0] r;
    vmem[14'h1234] = 8'h5A; m_mem[14'h1234] = 8'h5A;
    re_log.delete();
    ctrl(8'h34); ctrl(8'h12);
    checks++; if (re_log.size() != 1 || re_log[0] !== 14'h1234) begin fails++; $display("FAIL rd_setup_re: got n=%0d addr=%h want n=1 addr=1234", re_log.size(), (re_log.size() > 0) ? re_log[0] : 14'h0); end
    io(0, 1, 0, 8'h00); m_data_rd(r);
    checks++; if (s_dout !== 8'h5A || s_dout !== r) begin fails++; $display("FAIL rd_data: got %h want 5a", s_dout); end
    gap();
    checks++; if (re_log.size() != 2 || re_log[1] !== 14'h1235) begin fails++; $display("FAIL rd_next_re: got n=%0d want n=2 addr=1235", re_log.size()); end
    checks++; if (vram_addr !== 14'h1236) begin fails++; $display("FAIL rd_end_addr: got %h want 1236", vram_addr); end
    checks++; if (cpu_dout !== m_buf) begin fails++; $display("FAIL rd_buf: got %h want %h", cpu_dout, m_buf); end
  endtask

  task automatic test_registers();
    ctrl(8'h0E); ctrl(8'h87);
    checks++; if (back_color !== 4'hE || text_color !== 4'h0) begin fails++; $display("FAIL reg_r7: got text=%h back=%h want 0 e", text_color, back_color); end
    ctrl(8'h02); ctrl(8'h80);
    checks++; if (mode !== 2'd2) begin fails++; $display("FAIL reg_mode: got %0d want 2", mode); end
    ctrl(8'h06); ctrl(8'h82);
    checks++; if (name_table_addr !== 14'h1800) begin fails++; $display("FAIL reg_name: got %h want 1800", name_table_addr); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ctrl(v); ctrl(8'h80 | 8'(i));
      checks++; if (obs_regs !== exp_outputs()) begin fails++; $display("FAIL reg_rand%0d: got %h want %h", i, obs_regs, exp_outputs()); end
    end
  endtask

  task automatic test_latch_reset();
    logic [7:0] s;
    ctrl(8'h12);
    io(0, 1, 1, 8'h00); m_stat_rd(s); gap();
    ctrl(8'h80);
    checks++; if (obs_regs !== exp_outputs()) begin fails++; $display("FAIL latch_regs: got %h want %h", obs_regs, exp_outputs()); end
    ctrl(8'h47);
    checks++; if (vram_addr !== 14'h0780) begin fails++; $display("FAIL latch_addr: got %h want 0780", vram_addr); end
  endtask

  task automatic test_interrupt();
    logic [7:0] s;
    logic [4:0] a, b;
    ctrl(8'h20); ctrl(8'h81);
    checks++; if (n_int !== 1'b1) begin fails++; $display("FAIL int_idle: got %b want 1", n_int); end
    frame_int = 1'b1; tick(); frame_int = 1'b0; m_F = 1;
    checks++; if (n_int !== 1'b0) begin fails++; $display("FAIL int_assert: got %b want 0", n_int); end
    tick();
    io(0, 1, 1, 8'h00); m_stat_rd(s);
    checks++; if (s_dout !== 8'h80 || s_dout !== s) begin fails++; $display("FAIL int_status: got %h want 80", s_dout); end
    checks++; if (n_int !== 1'b1) begin fails++; $display("FAIL int_clear: got %b want 1", n_int); end
    gap();
    // frame pulse coinciding with the read: read sees old F, F stays set
    frame_int = 1'b1; io(0, 1, 1, 8'h00); frame_int = 1'b0;
    m_stat_rd(s); m_F = 1;
    checks++; if (s_dout !== 8'h00 || s_dout !== s) begin fails++; $display("FAIL int_race_read: got %h want 00", s_dout); end
    checks++; if (n_int !== 1'b0) begin fails++; $display("FAIL int_race_keep: got %b want 0", n_int); end
    gap();
    io(0, 1, 1, 8'h00); m_stat_rd(s);
    checks++; if (s_dout !== 8'h80) begin fails++; $display("FAIL int_race_status: got %h want 80", s_dout); end
    gap();
    // collision and fifth-sprite capture, fifth frozen while 5S is set
    a = 5'($urandom); b = a ^ 5'h15;
    sprite5 = a; tick();
    sprite_collision = 1'b1; too_many_sprites = 1'b1; tick();
    sprite_collision = 1'b0; too_many_sprites = 1'b0;
    m_C = 1; m_5S = 1; m_fifth = a;
    sprite5 = b; gap();
    io(0, 1, 1, 8'h00); m_stat_rd(s);
    checks++; if (s_dout !== {3'b011, a} || s_dout !== s) begin fails++; $display("FAIL spr_status: got %h want %h", s_dout, {3'b011, a}); end
    gap(); m_fifth = b;
    io(0, 1, 1, 8'h00); m_stat_rd(s);
    checks++; if (s_dout !== {3'b000, b} || s_dout !== s) begin fails++; $display("FAIL spr_track: got %h want %h", s_dout, {3'b000, b}); end
    gap();
    sprite5 = 5'd0; gap(); m_fifth = 5'd0;
  endtask

  task automatic test_wrap_overrun();
    logic [7:0] r;
    ctrl(8'hFF); ctrl(8'h7F);
    io(1, 0, 0, 8'h11); m_data_wr(8'h11);
    checks++; if (s_we !== 1'b1 || s_addr !== 14'h3FFF) begin fails++; $display("FAIL wrap_wr: got we=%b addr=%h want 1 3fff", s_we, s_addr); end
    gap();
    checks++; if (vram_addr !== 14'h0000) begin fails++; $display("FAIL wrap_addr: got %h want 0000", vram_addr); end
    io(0, 1, 0, 8'h00); m_data_rd(r);
    checks++; if (s_dout !== 8'h11) begin fails++; $display("FAIL ovr_read: got %h want 11", s_dout); end
    io(1, 0, 0, 8'h99);
    checks++; if (s_we !== 1'b0) begin fails++; $display("FAIL ovr_drop_we: got %b want 0", s_we); end
    gap();
    checks++; if (dut.err_overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", dut.err_overrun); end
    checks++; if (cpu_dout !== m_buf || vram_addr !== 14'(m_addr)) begin fails++; $display("FAIL ovr_state: got buf=%h addr=%h want buf=%h addr=%h", cpu_dout, vram_addr, m_buf, 14'(m_addr)); end
  endtask

  task automatic test_random();
    logic [7:0] d, r;
    int kind;
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 3));
      d = 8'($urandom);
      case (kind)
        0: begin
          io(1, 0, 0, d);
          checks++; if (s_we !== 1'b1 || s_addr !== 14'(m_addr)) begin fails++; $display("FAIL rnd_wr%0d: got we=%b addr=%h want 1 %h", n, s_we, s_addr, 14'(m_addr)); end
          m_data_wr(d);
        end
        1: begin
          io(0, 1, 0, d); m_data_rd(r);
          checks++; if (s_dout !== r) begin fails++; $display("FAIL rnd_rd%0d: got %h want %h", n, s_dout, r); end
        end
        2: begin
          io(1, 0, 1, d); m_ctrl_wr(d);
        end
        default: begin
          io(0, 1, 1, d); m_stat_rd(r);
          checks++; if (s_dout !== r) begin fails++; $display("FAIL rnd_st%0d: got %h want %h", n, s_dout, r); end
        end
      endcase
      gap();
      checks++; if (vram_addr !== 14'(m_addr) || cpu_dout !== m_buf) begin fails++; $display("FAIL rnd_port%0d: got addr=%h buf=%h want addr=%h buf=%h", n, vram_addr, cpu_dout, 14'(m_addr), m_buf); end
      checks++; if (obs_regs !== exp_outputs() || n_int !== 1'b1) begin fails++; $display("FAIL rnd_regs%0d: got %h int=%b want %h int=1", n, obs_regs, n_int, exp_outputs()); end
    end
  endtask

  initial begin
    n_reset = 1'b0; io_port = 1'b0; io_wr = 1'b0; io_rd = 1'b0; cpu_din = 8'h00;
    frame_int = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0; sprite5 = 5'd0;
    vram_din = 8'h00;
    for (int i = 0; i < 16384; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      vmem[i] = v; m_mem[i] = v;
    end
    test_reset();
    test_write_setup();
    test_read_prefetch();
    test_registers();
    test_latch_reset();
    test_interrupt();
    test_wrap_overrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-side end of the VDP: decodes Z80 I/O accesses to the data port (0x98) and control port (0x99).
- Drives VRAM port A (address, write data, write enable, read enable) with an auto-incrementing 14-bit address, a read-ahead buffer and a two-byte control latch.
- Holds VDP registers R0-R7 and breaks them out into the mode, table-address, colour and sprite-control signals consumed by the video generator.
- Keeps the status register and drives the active-low interrupt to the CPU.

Parameters:
- ADDR_W, 14, VRAM address width; address wraps modulo 2^ADDR_W.
- NREGS, 8, number of write-only VDP registers.

Ports:
- cpu_clk  in  1  single clock; same clock as VRAM port A.
- n_reset  in  1  synchronous, active-low reset.
- io_port  in  1  0 = data port, 1 = control port.
- io_wr  in  1  one-cycle write strobe.
- io_rd  in  1  one-cycle read strobe.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- vram_addr  out  14  VRAM address.
- vram_dout  out  8  VRAM write data.
- vram_we  out  1  VRAM write enable.
- vram_re  out  1  VRAM read enable.
- vram_din  in  8  VRAM read data, valid 1 cycle after vram_re.
- frame_int  in  1  one-cycle vertical-retrace pulse from the video block.
- sprite_collision  in  1  collision event.
- too_many_sprites  in  1  fifth-sprite event.
- sprite5  in  5  fifth-sprite number.
- mode  out  2  0 text, 1 graphics I, 2 graphics II, 3 multicolour.
- name_table_addr  out  14  {R2[3:0], 10'b0}.
- color_table_addr  out  14  {R3, 6'b0}.
- font_addr  out  14  {R4[2:0], 11'b0}.
- sprite_attr_addr  out  14  {R5[6:0], 7'b0}.
- sprite_pattern_table_addr  out  14  {R6[2:0], 11'b0}.
- text_color  out  4  R7[7:4].
- back_color  out  4  R7[3:0].
- video_on  out  1  R1[6].
- vert_retrace_int  out  1  R1[5], interrupt enable.
- sprite_large  out  1  R1[1].
- sprite_enlarged  out  1  R1[0].
- n_int  out  1  active-low interrupt = !(F && R1[5]).

Behaviour:
- Reset (n_reset=0 at edge):
  - All registers 0, address 0, read_buf 0, latch_flag 0, status 0, state IDLE.
  - vram_we, vram_re = 0; n_int = 1.
  - Reset mid-prefetch abandons the capture.
- Mode decode (M1=R1[4], M2=R1[3], M3=R0[1]):
  - M1 gives 0; M3 gives 2; M2 gives 3; otherwise 1.
  - Priority M1 > M3 > M2.
- Data write (io_wr, port 0):
  - Same cycle: vram_we=1, vram_addr=addr, vram_dout=cpu_din; read_buf <= cpu_din.
  - addr <= addr+1, wrapping 3FFF to 0000.
  - latch_flag <= 0.
- Data read (io_rd, port 0):
  - cpu_dout = read_buf, combinational in the strobe cycle.
  - Next cycle: state PREFETCH, vram_re=1 with addr; addr <= addr+1.
  - Following cycle: read_buf <= vram_din; state back to IDLE.
  - latch_flag <= 0.
- Control write (io_wr, port 1):
  - If latch_flag=0: first <= cpu_din, latch_flag <= 1.
  - Else latch_flag <= 0, decoded on cpu_din[7:6]:
    - 1x: register write, R[cpu_din[2:0]] <= first.
    - 01: addr <= {cpu_din[5:0], first}, write setup, no VRAM access.
    - 00: addr set as for 01, then prefetch as for a data read (vram_re, read_buf capture, addr+1).
- Status read (io_rd, port 1):
  - cpu_dout = {F, 5S, C, fifth[4:0]}.
  - Next edge: F, 5S, C cleared; latch_flag <= 0.
- Status set:
  - frame_int sets F; sprite_collision sets C.
  - too_many_sprites with 5S=0 sets 5S and captures sprite5.
  - fifth[4:0] holds sprite5 while 5S=0; frozen while 5S=1.
  - Set coinciding with a clearing status read: set wins; the read returns the pre-set value.
- cpu_dout with no read strobe = read_buf.
- Access spacing: strobes are at least 3 cycles apart (Z80 I/O timing). A strobe arriving in PREFETCH is dropped, and the sticky output-less flag err_overrun is raised for assertions.
- io_wr and io_rd asserted together: write taken, read ignored.

Decomposition:
- vdp_pkg:
  - mode encodings (MODE_TEXT=0, MODE_G1=1, MODE_G2=2, MODE_MC=3);
  - register indices R0-R7 and R1 bit positions (BLANK=6, IE=5, M1=4, M2=3, SIZE=1, MAG=0);
  - status bit positions (F=7, 5S=6, C=5);
  - state enum IDLE/PREFETCH.
- One sub-module: vdp_status_latch (F/5S/C/fifth set-clear logic and n_int).

Test Plan:
- Reset, then control writes 0x00,0x40, then data writes 0xAA,0xBB -> vram_we pulses at addr 0x0000 and 0x0001; internal addr ends at 0x0002.
- Control writes 0x34,0x12 -> addr=0x1234, vram_re asserted once at 0x1234; later data read returns the prefetched byte 0x5A while the next prefetch hits 0x1235.
- Control writes 0x0E,0x87 -> back_color=0xE, text_color=0x0; writes 0x02,0x80 -> mode=2; writes 0x06,0x82 -> name_table_addr=0x1800.
- Control write 0x12, then status read, then control write 0x80 -> treated as a first byte; no register changes.
- frame_int pulse with R1=0x20 -> n_int=0 and status read returns 0x80; next cycle n_int=1. A frame_int in the same cycle as the read keeps F=1.
- Data write at addr 0x3FFF -> addr wraps to 0x0000; a strobe 1 cycle after a data read -> dropped, err_overrun=1, read_buf unchanged.
